// File: rtl/ram_burst_tracker_if.sv
// ram_burst_tracker_if: filtered RAM bus samples in, word transactions out
interface ram_burst_tracker_if;
  logic [22:0] filter_a;
  logic [15:0] filter_d;
  logic [1:0] filter_ublb;
  logic filter_read;
  logic filter_write;
  logic filter_addr_latch;
  logic filter_strobe;
  logic word_valid;
  logic word_ready;
  logic [22:0] word_addr;
  logic [15:0] word_data;
  logic [1:0] word_ublb;
  logic word_write;
  logic word_first;
  modport slave (
    input filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch, filter_strobe, word_ready,
    output word_valid, word_addr, word_data, word_ublb, word_write, word_first
  );
  modport master (
    output filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch, filter_strobe, word_ready,
    input word_valid, word_addr, word_data, word_ublb, word_write, word_first
  );
endinterface

// File: rtl/ram_burst_tracker.sv
// ram_burst_tracker: follows synchronous-burst RAM accesses and queues each data word in a FWFT FIFO
module ram_burst_tracker #(
  parameter int LATENCY = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic mclk,
  input logic reset_n,
  ram_burst_tracker_if.slave bus,
  output logic busy,
  output logic overflow,
  output logic proto_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;
  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0] ublb;
    logic write;
    logic first;
  } word_t;
  state_t state, state_nx;
  logic [22:0] cur_addr, addr_nx;
  logic [3:0] lat_cnt, lat_nx;
  logic first_pending, first_nx;
  logic emit, rw, push_ok, pop, full, empty;
  logic [AW:0] wr_ptr, rd_ptr;
  word_t mem [FIFO_DEPTH];
  word_t head;
  assign rw = bus.filter_read | bus.filter_write;
  // addr_nx is also the address of the emitted word: increment happens before emit in a burst
  always_comb begin
    state_nx = state;
    addr_nx = cur_addr;
    lat_nx = lat_cnt;
    first_nx = first_pending;
    emit = 1'b0;
    if (bus.filter_strobe) begin
      if (bus.filter_addr_latch) begin
        addr_nx = bus.filter_a;
        lat_nx = 4'(LATENCY - 1);
        first_nx = 1'b1;
        state_nx = LAT;
      end else if (state == LAT) begin
        lat_nx = (lat_cnt != 4'd0) ? lat_cnt - 4'd1 : lat_cnt;
        emit = (lat_cnt == 4'd0) && rw;
        state_nx = (lat_cnt != 4'd0) ? LAT : rw ? BURST : IDLE;
      end else if (state == BURST) begin
        addr_nx = rw ? cur_addr + 23'd1 : cur_addr;
        emit = rw;
        state_nx = rw ? BURST : IDLE;
      end
      first_nx = emit ? 1'b0 : first_nx;
    end
  end
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = !empty && bus.word_ready;
  assign push_ok = emit && (!full || pop);
  assign head = mem[rd_ptr[AW-1:0]];
  assign bus.word_valid = !empty;
  assign bus.word_addr = empty ? '0 : head.addr;
  assign bus.word_data = empty ? '0 : head.data;
  assign bus.word_ublb = empty ? '0 : head.ublb;
  assign bus.word_write = !empty && head.write;
  assign bus.word_first = !empty && head.first;
  assign busy = state != IDLE;
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state <= IDLE;
      cur_addr <= '0;
      lat_cnt <= '0;
      first_pending <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      cur_addr <= addr_nx;
      lat_cnt <= lat_nx;
      first_pending <= first_nx;
      wr_ptr <= wr_ptr + (AW+1)'(push_ok);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      overflow <= overflow | (emit && full && !pop);
      proto_err <= proto_err | (emit && bus.filter_read && bus.filter_write);
    end
  end
  always_ff @(posedge mclk) begin
    if (reset_n && push_ok)
      mem[wr_ptr[AW-1:0]] <= '{addr_nx, bus.filter_d, bus.filter_ublb, bus.filter_write, first_pending};
  end
endmodule
